// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator feeding the 10-row Wallace-tree reducer.
// Two-stage valid/ready pipeline: stage 1 encodes Booth digits, stage 2 forms the rows.
module booth_pp_gen #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int NUM_PP    = 10,
  parameter int PP_WIDTH  = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [A_WIDTH-1:0]          in_a,
  input  logic [B_WIDTH-1:0]          in_b,
  input  logic                        in_signed,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_PP*PP_WIDTH-1:0]  pp_flat,
  output logic [TAG_WIDTH-1:0]        out_tag
);

  localparam int G  = B_WIDTH / 2 + 1;
  localparam int BX = 2 * G;

  // Stage 1 state
  logic                      s1_valid_reg;
  logic [G-1:0]              neg_reg;
  logic [G-1:0]              one_reg;
  logic [G-1:0]              two_reg;
  logic [PP_WIDTH-1:0]       a_ext_reg;
  logic [TAG_WIDTH-1:0]      s1_tag_reg;

  // Stage 2 state
  logic                      out_valid_reg;
  logic [NUM_PP*PP_WIDTH-1:0] pp_reg;
  logic [TAG_WIDTH-1:0]      out_tag_reg;

  logic s2_adv;
  logic in_fire;

  // Ready is combinational from the downstream so a full pipe still streams 1 op/cycle.
  assign s2_adv   = !out_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_adv;
  assign in_fire  = in_valid && in_ready;

  logic                 a_sign;
  logic                 b_sign;
  logic [BX-1:0]        b_ext;
  logic [BX:0]          b_pad;
  logic [PP_WIDTH-1:0]  a_ext_next;

  assign a_sign     = in_signed & in_a[A_WIDTH-1];
  assign b_sign     = in_signed & in_b[B_WIDTH-1];
  assign b_ext      = {{(BX-B_WIDTH){b_sign}}, in_b};
  assign b_pad      = {b_ext, 1'b0};
  assign a_ext_next = {{(PP_WIDTH-A_WIDTH){a_sign}}, in_a};

  logic [G-1:0] neg_next;
  logic [G-1:0] one_next;
  logic [G-1:0] two_next;

  genvar gi;
  generate
    for (gi = 0; gi < G; gi++) begin : g_enc
      logic [2:0] grp;
      assign grp          = b_pad[2*gi+2 -: 3];
      assign one_next[gi] = grp[1] ^ grp[0];
      assign two_next[gi] = (grp == 3'b011) || (grp == 3'b100);
      // 111 encodes zero, so it must not raise the negate flag.
      assign neg_next[gi] = grp[2] && !(grp[1] && grp[0]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      neg_reg      <= '0;
      one_reg      <= '0;
      two_reg      <= '0;
      a_ext_reg    <= '0;
      s1_tag_reg   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
      end
      if (in_fire) begin
        neg_reg    <= neg_next;
        one_reg    <= one_next;
        two_reg    <= two_next;
        a_ext_reg  <= a_ext_next;
        s1_tag_reg <= in_tag;
      end
    end
  end

  logic [NUM_PP*PP_WIDTH-1:0] pp_next;
  logic [PP_WIDTH-1:0]        corr_row;

  generate
    for (gi = 0; gi < G; gi++) begin : g_row
      logic [PP_WIDTH-1:0] mag;
      logic [PP_WIDTH-1:0] sel;
      always_comb begin
        mag = '0;
        if (one_reg[gi]) begin
          mag = a_ext_reg;
        end else if (two_reg[gi]) begin
          mag = a_ext_reg << 1;
        end
      end
      // One's-complement here; the matching +1 lands in the correction row.
      assign sel = neg_reg[gi] ? ~mag : mag;
      assign pp_next[gi*PP_WIDTH +: PP_WIDTH] = sel << (2*gi);
      assign corr_row[2*gi]   = neg_reg[gi];
      assign corr_row[2*gi+1] = 1'b0;
    end
    for (gi = 2*G; gi < PP_WIDTH; gi++) begin : g_corr_hi
      assign corr_row[gi] = 1'b0;
    end
    for (gi = G; gi < NUM_PP-1; gi++) begin : g_pad
      assign pp_next[gi*PP_WIDTH +: PP_WIDTH] = '0;
    end
  endgenerate

  assign pp_next[(NUM_PP-1)*PP_WIDTH +: PP_WIDTH] = corr_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      pp_reg        <= '0;
      out_tag_reg   <= '0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        pp_reg      <= pp_next;
        out_tag_reg <= s1_tag_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign pp_flat   = pp_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_booth_pp_gen.sv
// Directed and random checks of the Booth partial-product generator:
// row contents, row sums, latency, backpressure, tag order and async reset.
module tb_booth_pp_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_a = '0;
  logic [15:0]  in_b = '0;
  logic         in_signed = 1'b0;
  logic [3:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [319:0] pp_flat;
  logic [3:0]   out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_pp_gen #(
    .A_WIDTH(16), .B_WIDTH(16), .NUM_PP(10), .PP_WIDTH(32), .TAG_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .pp_flat(pp_flat), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] row_sum(input logic [319:0] pp);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 10; k++) s = s + pp[k*32 +: 32];
    return s;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [31:0] ax;
    logic [31:0] bx;
    ax = s ? {{16{a[15]}}, a} : {16'h0, a};
    bx = s ? {{16{b[15]}}, b} : {16'h0, b};
    return ax * bx;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [3:0] t);
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    logic [31:0] r;
    r = $urandom();
    in_a = r[15:0];
    in_b = r[31:16];
    r = $urandom();
    in_signed = r[0];
    in_tag = r[7:4];
    in_valid = 1'b1;
  endtask

  // Sends one op into an empty pipe with out_ready=1; lat = edges from accept to output transfer.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [3:0] t,
                        output logic [319:0] pp, output logic [3:0] tg, output int lat);
    bit got_in;
    got_in = 1'b0;
    pp = '0; tg = '0; lat = -1;
    drive(a, b, s, t);
    for (int i = 0; i < 20 && !got_in; i++) begin
      @(negedge clk);
      if (in_ready) got_in = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got_in) return;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        pp = pp_flat; tg = out_tag; lat = i + 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [319:0] pp, expv, snap;
  logic [3:0]   tg;
  int           lat;
  logic [15:0]  bp_a [3] = '{16'd100, 16'hFFF9, 16'h1234};
  logic [15:0]  bp_b [3] = '{16'd200, 16'd9, 16'h0010};
  logic         bp_s [3] = '{1'b0, 1'b1, 1'b0};
  logic [31:0]  bp_sum [3] = '{32'h0000_4E20, 32'hFFFF_FFC1, 32'h0001_2340};
  logic [31:0]  q_p [$];
  logic [3:0]   q_t [$];

  initial begin
    int idx, accepts, stable_bad, nout, sent, rcvd;
    bit in_f, out_f, have_snap, pre_valid;
    logic [31:0] p;
    logic [3:0]  t;
    localparam int N = 2000;

    // Reset state
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pp_flat", pp_flat, 0);
    chk("rst_out_tag", out_tag, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: unsigned 3*5
    run_op(16'd3, 16'd5, 1'b0, 4'h1, pp, tg, lat);
    expv = '0; expv[31:0] = 32'h3; expv[63:32] = 32'hC;
    chk("t1_rows", pp, expv);
    chk("t1_sum", row_sum(pp), 32'd15);
    chk("t1_lat", lat, 2);
    chk("t1_tag", tg, 4'h1);

    // 2: signed -1*-1
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 4'h2, pp, tg, lat);
    expv = '0; expv[9*32 +: 32] = 32'h1;
    chk("t2_rows", pp, expv);
    chk("t2_sum", row_sum(pp), 32'd1);
    chk("t2_tag", tg, 4'h2);

    // 3: unsigned 0xFFFF*0xFFFF, needs the ninth digit
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 4'h3, pp, tg, lat);
    expv = '0; expv[31:0] = 32'hFFFF_0000; expv[8*32 +: 32] = 32'hFFFF_0000; expv[9*32 +: 32] = 32'h1;
    chk("t3_rows", pp, expv);
    chk("t3_sum", row_sum(pp), 32'hFFFE_0001);

    // signed -2*3
    run_op(16'hFFFE, 16'd3, 1'b1, 4'h4, pp, tg, lat);
    expv = '0; expv[31:0] = 32'h1; expv[63:32] = 32'hFFFF_FFF8; expv[9*32 +: 32] = 32'h1;
    chk("neg2x3_rows", pp, expv);
    chk("neg2x3_sum", row_sum(pp), 32'hFFFF_FFFA);

    // unsigned 0x8000*0x8000: -2 digit in group 7, correction bit at 14
    run_op(16'h8000, 16'h8000, 1'b0, 4'h5, pp, tg, lat);
    expv = '0; expv[7*32 +: 32] = 32'hBFFF_C000; expv[8*32 +: 32] = 32'h8000_0000; expv[9*32 +: 32] = 32'h0000_4000;
    chk("m8000_rows", pp, expv);
    chk("m8000_sum", row_sum(pp), 32'h4000_0000);

    // 4: backpressure, 3 ops offered while out_ready=0 for 5 cycles
    out_ready = 1'b0;
    idx = 0; accepts = 0; stable_bad = 0; have_snap = 1'b0; snap = '0;
    drive(bp_a[0], bp_b[0], bp_s[0], 4'd5);
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      in_f = in_valid && in_ready;
      if (in_f) accepts++;
      if (out_valid) begin
        if (!have_snap) begin snap = pp_flat; have_snap = 1'b1; end
        else if (pp_flat !== snap) stable_bad++;
      end
      @(posedge clk); #1;
      if (in_f) begin
        idx++;
        if (idx < 3) drive(bp_a[idx], bp_b[idx], bp_s[idx], 4'(5 + idx));
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("bp_accepts", accepts, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_stable", stable_bad, 0);
    chk("bp_hold_pp", pp_flat, snap);
    chk("bp_hold_tag", out_tag, 4'd5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    nout = 0;
    for (int cyc = 0; cyc < 30 && nout < 3; cyc++) begin
      @(negedge clk);
      in_f = in_valid && in_ready;
      if (out_valid) begin
        chk("bp_tag", out_tag, 4'(5 + nout));
        chk("bp_sum", row_sum(pp_flat), bp_sum[nout]);
        nout++;
      end
      @(posedge clk); #1;
      if (in_f) begin
        idx++;
        if (idx < 3) drive(bp_a[idx], bp_b[idx], bp_s[idx], 4'(5 + idx));
        else in_valid = 1'b0;
      end
    end
    chk("bp_count", nout, 3);
    @(negedge clk);
    chk("bp_no_dup", out_valid, 0);
    @(posedge clk); #1;

    // 5: random stream with random backpressure
    sent = 0; rcvd = 0;
    out_ready = 1'b1;
    drive_rand();
    for (int cyc = 0; cyc < 20000 && rcvd < N; cyc++) begin
      @(negedge clk);
      in_f  = in_valid && in_ready;
      out_f = out_valid && out_ready;
      if (out_f) begin
        if (q_p.size() == 0) begin
          chk("rnd_extra", 1, 0);
        end else begin
          p = q_p.pop_front();
          t = q_t.pop_front();
          chk("rnd_sum", row_sum(pp_flat), p);
          chk("rnd_tag", out_tag, t);
        end
        rcvd++;
      end
      if (in_f) begin
        q_p.push_back(ref_prod(in_a, in_b, in_signed));
        q_t.push_back(in_tag);
        sent++;
      end
      @(posedge clk); #1;
      if (in_f) begin
        if (sent < N) drive_rand();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("rnd_count", rcvd, N);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // 6: async reset with work in flight
    out_ready = 1'b0;
    drive(16'h1111, 16'h2222, 1'b0, 4'h9);
    pre_valid = 1'b0;
    for (int cyc = 0; cyc < 10 && !pre_valid; cyc++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        @(posedge clk); #1;
        drive(16'h3333, 16'h4444, 1'b0, 4'hB);
      end else begin
        @(posedge clk); #1;
      end
      if (out_valid) pre_valid = 1'b1;
    end
    chk("rst6_pre_valid", pre_valid, 1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst6_out_valid", out_valid, 0);
    chk("rst6_pp_flat", pp_flat, 0);
    chk("rst6_out_tag", out_tag, 0);
    chk("rst6_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst6_stay_idle", out_valid, 0);
    run_op(16'd2, 16'd7, 1'b0, 4'hA, pp, tg, lat);
    chk("rst6_sum", row_sum(pp), 32'd14);
    chk("rst6_tag", tg, 4'hA);
    chk("rst6_lat", lat, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
